// File: rtl/uart_tx_fifo_top_if.sv
// Host-side bundle for the buffered UART transmitter: byte writes, frame config,
// flow control, and the serial line plus FIFO status coming back.
interface uart_tx_fifo_top_if #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DVSR_W     = 11
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DVSR_W-1:0] dvsr;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic [1:0]        data_bit_num;
    logic              stop_bit_num;
    logic              parity_en;
    logic              parity_type;
    logic              cts_n;
    logic              tx;
    logic              tx_done;
    logic              tx_busy;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;

    modport master (
        output dvsr, wr_en, wr_data, data_bit_num, stop_bit_num, parity_en, parity_type, cts_n,
        input  tx, tx_done, tx_busy, fifo_full, fifo_empty, fifo_level, overflow
    );

    modport slave (
        input  dvsr, wr_en, wr_data, data_bit_num, stop_bit_num, parity_en, parity_type, cts_n,
        output tx, tx_done, tx_busy, fifo_full, fifo_empty, fifo_level, overflow
    );
endinterface

// File: rtl/uart_tx_fifo_top.sv
// Buffered UART transmitter: write FIFO, oversampled baud tick generator and a
// frame serialiser that drains queued bytes back-to-back onto tx.
module uart_tx_fifo_top #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DVSR_W     = 11,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_fifo_top_if.slave    bus
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned TW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Baud tick: counter wraps naturally if dvsr drops below the current count
    logic [DVSR_W-1:0] baud_q, baud_d;
    logic              tick_c;

    always_comb begin
        tick_c = (baud_q == bus.dvsr);
        baud_d = tick_c ? '0 : baud_q + DVSR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) baud_q <= '0;
        else     baud_q <= baud_d;
    end

    // FIFO storage and status
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, empty_q, ovf_q;
    logic             push_c, pop_c;
    state_t           state_q;

    always_comb begin
        push_c  = bus.wr_en && !full_q;
        pop_c   = (state_q == S_IDLE) && tick_c && !empty_q && !bus.cts_n;
        level_d = level_q;
        if (push_c && !pop_c)      level_d = level_q + LVL_W'(1);
        else if (pop_c && !push_c) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == LVL_W'(FIFO_DEPTH));
            empty_q <= (level_d == '0);
            if (bus.wr_en && full_q) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    // Frame serialiser; frame config is latched at pop so mid-frame changes are ignored
    logic [TW-1:0] tcnt_q;
    logic [2:0]    bcnt_q;
    logic [7:0]    shift_q;
    logic          par_q, scnt_q;
    logic [1:0]    dbn_q;
    logic          sbn_q, pen_q, ptype_q;
    logic          tx_q, done_q, busy_q;
    logic          bit_end_c;

    assign bit_end_c = tick_c && (tcnt_q == TW'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            scnt_q  <= 1'b0;
            dbn_q   <= '0;
            sbn_q   <= 1'b0;
            pen_q   <= 1'b0;
            ptype_q <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tick_c && state_q != S_IDLE) tcnt_q <= bit_end_c ? '0 : tcnt_q + TW'(1);
            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        state_q <= S_START;
                        shift_q <= mem_q[rd_ptr_q];
                        dbn_q   <= bus.data_bit_num;
                        sbn_q   <= bus.stop_bit_num;
                        pen_q   <= bus.parity_en;
                        ptype_q <= bus.parity_type;
                        tcnt_q  <= '0;
                        bcnt_q  <= '0;
                        scnt_q  <= 1'b0;
                        par_q   <= 1'b0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end_c) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        par_q   <= par_q ^ shift_q[0];
                        bcnt_q  <= bcnt_q + 3'd1;
                        // last data bit index is 4 + data_bit_num
                        if (bcnt_q == {1'b1, dbn_q}) begin
                            if (pen_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_q ^ shift_q[0] ^ ptype_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end_c) begin
                        if (scnt_q == sbn_q) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            scnt_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_busy    = busy_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo_top.sv
// Directed bench for uart_tx_fifo_top: expected frames are queued at write time
// and compared bit-by-bit (mid-bit sampling) as the DUT serialises them.
module tb_uart_tx_fifo_top;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 11;
    localparam int unsigned OS    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_top_if #(.FIFO_DEPTH(DEPTH), .DVSR_W(DW)) bus();
    uart_tx_fifo_top #(.FIFO_DEPTH(DEPTH), .DVSR_W(DW), .OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    frame_t sb[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_run = 0;
    int done_max = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.tx_done === 1'b1) begin
            done_run++;
            if (done_run > done_max) done_max = done_run;
        end else begin
            done_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t make_frame(input logic [7:0] b, input logic [1:0] dbn,
                                          input logic sbn, input logic pen, input logic ptype);
        frame_t f;
        int     n;
        logic   p;
        n      = 5 + int'(dbn);
        p      = ptype;
        f.bits = '1;
        f.bits[0] = 1'b0;
        f.len  = 1;
        for (int i = 0; i < n; i++) begin
            f.bits[f.len] = b[i];
            p = p ^ b[i];
            f.len++;
        end
        if (pen) begin
            f.bits[f.len] = p;
            f.len++;
        end
        f.len = f.len + 1 + int'(sbn);
        return f;
    endfunction

    task automatic write_byte(input logic [7:0] b, input bit accept);
        @(negedge clk);
        bus.wr_data = b;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        if (accept)
            sb.push_back(make_frame(b, bus.data_bit_num, bus.stop_bit_num,
                                    bus.parity_en, bus.parity_type));
    endtask

    task automatic recv_frame(input string tag, output int lvl_at_start);
        frame_t f;
        int     bt;
        int     t0;
        bit     seen;
        lvl_at_start = -1;
        bt = int'(OS) * (int'(bus.dvsr) + 1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) seen = 1'b1;
        end
        check({tag, "_start_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        t0 = cyc;
        lvl_at_start = int'(bus.fifo_level);
        check({tag, "_busy"}, 32'(bus.tx_busy), 32'd1);
        f = sb.pop_front();
        repeat (bt / 2) @(negedge clk);
        for (int i = 0; i < f.len; i++) begin
            if (i > 0) repeat (bt) @(negedge clk);
            check($sformatf("%s_bit%0d", tag, i), 32'(bus.tx), 32'(f.bits[i]));
        end
        seen = 1'b0;
        for (int i = 0; i < bt && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_time"}, 32'(cyc - t0), 32'(f.len * bt));
    endtask

    int  lvl;
    int  lows;
    bit  seen0;

    initial begin
        rst              = 1'b1;
        bus.dvsr         = '0;
        bus.wr_en        = 1'b0;
        bus.wr_data      = '0;
        bus.data_bit_num = 2'd3;
        bus.stop_bit_num = 1'b0;
        bus.parity_en    = 1'b0;
        bus.parity_type  = 1'b0;
        bus.cts_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx",       32'(bus.tx),         32'd1);
        check("rst_done",     32'(bus.tx_done),    32'd0);
        check("rst_busy",     32'(bus.tx_busy),    32'd0);
        check("rst_empty",    32'(bus.fifo_empty), 32'd1);
        check("rst_full",     32'(bus.fifo_full),  32'd0);
        check("rst_level",    32'(bus.fifo_level), 32'd0);
        check("rst_overflow", 32'(bus.overflow),   32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1, 0xA5
        write_byte(8'hA5, 1'b1);
        recv_frame("f8n1", lvl);
        check("f8n1_lvl", 32'(lvl), 32'd0);

        // 7E2, 0x83: bit 7 must not appear
        bus.data_bit_num = 2'd2; bus.parity_en = 1'b1; bus.parity_type = 1'b0; bus.stop_bit_num = 1'b1;
        write_byte(8'h83, 1'b1);
        recv_frame("f7e2", lvl);

        // 5O1, 0x00: odd parity of all-zero data is 1
        bus.data_bit_num = 2'd0; bus.parity_en = 1'b1; bus.parity_type = 1'b1; bus.stop_bit_num = 1'b0;
        write_byte(8'h00, 1'b1);
        recv_frame("f5o1", lvl);
        check("done_width_5o1", 32'(done_max), 32'd1);

        // CTS hold-off, release, re-assert mid-frame
        bus.data_bit_num = 2'd3; bus.parity_en = 1'b0; bus.parity_type = 1'b0; bus.stop_bit_num = 1'b0;
        bus.cts_n = 1'b1;
        write_byte(8'h11, 1'b1);
        write_byte(8'h5A, 1'b1);
        write_byte(8'hF0, 1'b1);
        repeat (200) @(negedge clk);
        check("cts_tx_idle", 32'(bus.tx),         32'd1);
        check("cts_busy",    32'(bus.tx_busy),    32'd0);
        check("cts_level3",  32'(bus.fifo_level), 32'd3);
        bus.cts_n = 1'b0;
        fork
            recv_frame("cts_f1", lvl);
            begin
                repeat (60) @(negedge clk);
                bus.cts_n = 1'b1;
            end
        join
        check("cts_f1_lvl", 32'(lvl), 32'd2);
        repeat (300) @(negedge clk);
        check("cts_hold_lvl",  32'(bus.fifo_level), 32'd2);
        check("cts_hold_busy", 32'(bus.tx_busy),    32'd0);
        bus.cts_n = 1'b0;
        recv_frame("cts_f2", lvl);
        check("cts_f2_lvl", 32'(lvl), 32'd1);
        recv_frame("cts_f3", lvl);
        check("cts_f3_lvl", 32'(lvl), 32'd0);

        // Overflow: fifth write into a 4-deep FIFO is dropped
        bus.cts_n = 1'b1;
        write_byte(8'h01, 1'b1);
        write_byte(8'h02, 1'b1);
        write_byte(8'h03, 1'b1);
        write_byte(8'h04, 1'b1);
        check("ovf_before", 32'(bus.overflow),  32'd0);
        check("full_at4",   32'(bus.fifo_full), 32'd1);
        write_byte(8'hEE, 1'b0);
        check("ovf_set",    32'(bus.overflow),   32'd1);
        check("ovf_level",  32'(bus.fifo_level), 32'd4);
        check("ovf_full",   32'(bus.fifo_full),  32'd1);
        bus.cts_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            recv_frame($sformatf("ovf_f%0d", k), lvl);
            check($sformatf("ovf_f%0d_lvl", k), 32'(lvl), 32'(3 - k));
        end
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (bus.tx === 1'b0) lows++;
        end
        check("ovf_no_extra", 32'(lows), 32'd0);
        check("ovf_empty",    32'(bus.fifo_empty), 32'd1);
        check("ovf_sticky",   32'(bus.overflow),   32'd1);

        // dvsr=2, reset in the middle of the data bits
        bus.dvsr = DW'(2);
        write_byte(8'h3C, 1'b0);
        write_byte(8'h55, 1'b0);
        seen0 = 1'b0;
        for (int i = 0; i < 2000 && !seen0; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) seen0 = 1'b1;
        end
        check("d2_start_seen", 32'(seen0), 32'd1);
        repeat (48 * 3 + 24) @(negedge clk);
        check("d2_busy_mid", 32'(bus.tx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx",       32'(bus.tx),         32'd1);
        check("mid_rst_empty",    32'(bus.fifo_empty), 32'd1);
        check("mid_rst_busy",     32'(bus.tx_busy),    32'd0);
        check("mid_rst_overflow", 32'(bus.overflow),   32'd0);
        check("mid_rst_level",    32'(bus.fifo_level), 32'd0);
        rst = 1'b0;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.tx === 1'b0) lows++;
        end
        check("post_rst_quiet", 32'(lows), 32'd0);
        check("done_width_all", 32'(done_max), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo_top.md
Name: uart_tx_fifo_top

Overview:
Parametrised UART transmit subsystem. It contains a write-side TX FIFO, an internal baud tick generator with oversampling, and a frame-serialising FSM. Frame format (5-8 data bits, optional parity, 1 or 2 stop bits) and CTS flow control are runtime-configurable. It replaces the single-byte TX top: software or an upstream block writes bytes, and the block drains them back-to-back onto tx.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of 2, 2..256
DVSR_W, 11, width of the baud divisor input
OVERSAMPLE, 16, baud ticks per serial bit; 1..64

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
dvsr  in  DVSR_W  baud divisor; tick period = dvsr+1 clk cycles
wr_en  in  1  push wr_data into FIFO
wr_data  in  8  byte to transmit, LSB sent first
data_bit_num  in  2  data bits = 5 + data_bit_num (00=5 .. 11=8)
stop_bit_num  in  1  0 = 1 stop bit, 1 = 2 stop bits
parity_en  in  1  insert parity bit after data
parity_type  in  1  0 = even, 1 = odd
cts_n  in  1  clear-to-send, active-low
tx  out  1  serial line, idles high
tx_done  out  1  one-cycle pulse at end of each frame
tx_busy  out  1  high from START entry until return to IDLE
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
fifo_empty  out  1  FIFO holds 0 entries
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: a write was dropped

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: tx=1, tx_done=0, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_level=0, overflow=0. Reset also sets baud counter=0, FSM=IDLE, and pointers=0.
- Reset mid-frame aborts the frame. tx=1 on the following cycle. FIFO contents are discarded.
- Baud generator:
  - counter increments each clk.
  - When counter==dvsr: tick=1 for one cycle and counter returns to 0.
  - dvsr=0 gives a tick every cycle.
  - A dvsr change takes effect immediately. If counter>dvsr, the counter wraps through its maximum value.
- FIFO:
  - Write accepted when wr_en && !fifo_full; fifo_level increments.
  - wr_en while full drops the data and sets overflow (sticky until rst). This holds even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Status outputs are registered and reflect state after the current cycle's push/pop.
  - Simultaneous accepted push and pop: fifo_level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. A per-state tick counter counts 0..OVERSAMPLE-1; a bit ends on the tick where the count = OVERSAMPLE-1.
- IDLE:
  - tx=1.
  - On a tick with !fifo_empty && !cts_n: pop the head into the shift register and latch data_bit_num, stop_bit_num, parity_en, parity_type. Next state is START.
  - cts_n is checked only here. Deassertion mid-frame does not stall or abort the frame.
- START: tx=0 for OVERSAMPLE ticks, then DATA.
- DATA:
  - tx = shift_reg[0]; shift right at each bit end.
  - After N = 5+data_bit_num bits, go to PARITY if parity_en, else STOP.
  - Bits above N-1 of the popped byte are ignored.
- PARITY:
  - tx = XOR of the N sent bits, inverted when parity_type=1.
  - Lasts one bit time, then STOP.
- STOP:
  - tx=1 for 1 or 2 bit times.
  - On the final stop tick: tx_done=1 for that single clk cycle and FSM returns to IDLE.
- Back-to-back frames: the next START can begin on the first tick after IDLE entry, so the inter-frame gap is ≤1 tick.
- Config inputs changed mid-frame do not affect the current frame.
- Frame length = OVERSAMPLE*(1+N+P+S) ticks.

Test Plan:
- dvsr=0, OVERSAMPLE=16, 8N1, cts_n=0, write 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 clk. tx_done pulses once, 160 clk after START entry.
- 7E2 (data_bit_num=10, parity_en=1, parity_type=0, stop_bit_num=1), write 0x83 → tx sequence 0, 1,1,0,0,0,0,0, 0 (even parity), 1,1. Bit 7 is not sent.
- cts_n=1, write 3 bytes → tx stays 1 and fifo_level=3. Drop cts_n → three frames back-to-back, fifo_level steps 2,1,0 at each frame start. Raising cts_n mid-frame 1 still completes that frame.
- FIFO_DEPTH=4, cts_n=1, write 5 bytes → fifo_full=1, fifo_level=4, overflow=1. Release cts_n → only the first 4 bytes are transmitted.
- dvsr=2 → tick every 3 clk, bit time = 48 clk. Assert rst mid-DATA → next cycle tx=1, fifo_empty=1, tx_busy=0, overflow=0.
- 5O1 odd parity, write 0x00 → data bits 0,0,0,0,0, parity bit=1, one stop bit. tx_done=1 for exactly 1 clk.
